// File: rtl/ram_pkg.sv
// Shared RAM-controller definitions: refresh FSM encoding, default strobe timings,
// and the width helper for the delay counter.
package ram_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCas  = 2'd1,
    StRas  = 2'd2,
    StPre  = 2'd3
  } refState_t;

  localparam int unsigned DefTcsr = 1;
  localparam int unsigned DefTras = 3;
  localparam int unsigned DefTrp  = 2;
  localparam int unsigned OwedW   = 2;

  // The counter is loaded with (delay - 1), so it must hold max-1.
  function automatic int unsigned dlyWidth(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 3) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ref_ctl_if.sv
// Timer/FSB inputs and RAM strobe/status outputs of the refresh scheduler.
interface ref_ctl_if;

  logic RefReq;
  logic RefUrg;
  logic BACT;
  logic nAS;
  logic nRAS;
  logic nCAS;
  logic RefBusy;
  logic RefHold;
  logic RefDone;
  logic RefMiss;

  modport slave (
    input  RefReq, RefUrg, BACT, nAS,
    output nRAS, nCAS, RefBusy, RefHold, RefDone, RefMiss
  );

  modport master (
    output RefReq, RefUrg, BACT, nAS,
    input  nRAS, nCAS, RefBusy, RefHold, RefDone, RefMiss
  );

endinterface

// File: rtl/dly_cnt.sv
// Loadable down-counter with zero flag; holds at zero when not loaded.
module dly_cnt #(
    parameter int unsigned Width = 2
) (
    input  logic             CLK,
    input  logic             nRESin,
    input  logic             load,
    input  logic [Width-1:0] loadVal,
    output logic [Width-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge CLK) begin
        if (!nRESin) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (cnt != '0) begin
            cnt <= cnt - Width'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ref_ctl.sv
// DRAM refresh scheduler: counts owed refreshes from the timer and runs
// CAS-before-RAS cycles whenever the FSB is idle.
module ref_ctl
    import ram_pkg::*;
#(
    parameter int unsigned TCSR = DefTcsr,
    parameter int unsigned TRAS = DefTras,
    parameter int unsigned TRP  = DefTrp
) (
    input logic      CLK,
    input logic      nRESin,
    ref_ctl_if.slave bus
);

    localparam int unsigned DlyW = dlyWidth(TCSR, TRAS, TRP);
    localparam logic [OwedW-1:0] OwedMax = '1;

    refState_t        state;
    logic             RefReqr;
    logic [OwedW-1:0] Owed;
    logic [OwedW-1:0] OwedD;
    logic             missD;
    logic             reqEdge;
    logic             startCond;
    logic             refEnd;
    logic             refDoneD;
    logic             dlyLoad;
    logic             dlyZero;
    logic [DlyW-1:0]  dlyVal;
    logic [DlyW-1:0]  Dly;

    dly_cnt #(
        .Width(DlyW)
    ) u_dly (
        .CLK    (CLK),
        .nRESin (nRESin),
        .load   (dlyLoad),
        .loadVal(dlyVal),
        .cnt    (Dly),
        .zero   (dlyZero)
    );

    always_comb begin
        reqEdge   = bus.RefReq && !RefReqr;
        startCond = (Owed != '0) && !bus.BACT && bus.nAS;
        refEnd    = (state == StPre) && dlyZero;

        OwedD = Owed;
        missD = 1'b0;
        if (reqEdge && !refEnd) begin
            if (Owed == OwedMax) missD = 1'b1;
            else                 OwedD = Owed + OwedW'(1);
        end else if (!reqEdge && refEnd) begin
            OwedD = Owed - OwedW'(1);
        end

        dlyLoad = 1'b0;
        dlyVal  = '0;
        case (state)
            StIdle: if (startCond) begin dlyLoad = 1'b1; dlyVal = DlyW'(TCSR - 1); end
            StCas:  if (dlyZero)   begin dlyLoad = 1'b1; dlyVal = DlyW'(TRAS - 1); end
            StRas:  if (dlyZero)   begin dlyLoad = 1'b1; dlyVal = DlyW'(TRP - 1);  end
            default: ;
        endcase

        // Registered RefDone must be high during the final PRE cycle.
        refDoneD = ((state == StPre) && (Dly == DlyW'(1))) ||
                   ((state == StRas) && dlyZero && (TRP == 1));
    end

    always_ff @(posedge CLK) begin
        if (!nRESin) begin
            RefReqr     <= 1'b0;
            Owed        <= '0;
            bus.RefMiss <= 1'b0;
            bus.RefHold <= 1'b0;
        end else begin
            RefReqr     <= bus.RefReq;
            Owed        <= OwedD;
            bus.RefMiss <= bus.RefMiss | missD;
            bus.RefHold <= bus.RefUrg && (OwedD != '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESin) begin
            state       <= StIdle;
            bus.nRAS    <= 1'b1;
            bus.nCAS    <= 1'b1;
            bus.RefBusy <= 1'b0;
            bus.RefDone <= 1'b0;
        end else begin
            bus.RefDone <= refDoneD;
            case (state)
                StIdle: if (startCond) begin
                    state       <= StCas;
                    bus.nCAS    <= 1'b0;
                    bus.RefBusy <= 1'b1;
                end
                StCas: if (dlyZero) begin
                    state    <= StRas;
                    bus.nRAS <= 1'b0;
                end
                StRas: if (dlyZero) begin
                    state    <= StPre;
                    bus.nRAS <= 1'b1;
                    bus.nCAS <= 1'b1;
                end
                StPre: if (dlyZero) begin
                    state       <= StIdle;
                    bus.RefBusy <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
